// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state, digit-step count and parameter legality for serial_adder
package serial_adder_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    function automatic int steps(input int width, input int digit);
        return digit > 0 ? width / digit : 1;
    endfunction
    function automatic bit legal(input int width, input int digit);
        return digit >= 1 && digit <= width && width % digit == 0;
    endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle; i_sub/o_overflow exist only with SERIAL_ADDER_SUB_EN
interface serial_adder_if #(parameter int WIDTH = 32);
    logic i_valid, o_ready, i_carry, o_valid, i_ready, o_carry;
    logic [WIDTH-1:0] i_x, i_y, o_sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic i_sub, o_overflow;
    modport master (output i_valid, i_x, i_y, i_carry, i_ready, i_sub,
                    input o_ready, o_valid, o_sum, o_carry, o_overflow);
    modport slave (input i_valid, i_x, i_y, i_carry, i_ready, i_sub,
                   output o_ready, o_valid, o_sum, o_carry, o_overflow);
`else
    modport master (output i_valid, i_x, i_y, i_carry, i_ready,
                    input o_ready, o_valid, o_sum, o_carry);
    modport slave (input i_valid, i_x, i_y, i_carry, i_ready,
                   output o_ready, o_valid, o_sum, o_carry);
`endif
endinterface

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple of full-adder cells; exports the MSB carry-in with SERIAL_ADDER_SUB_EN
module digit_adder #(parameter int DIGIT = 4) (
    input  logic [DIGIT-1:0] i_x,
    input  logic [DIGIT-1:0] i_y,
    input  logic             i_carry,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_carry
`ifdef SERIAL_ADDER_SUB_EN
    ,
    output logic             o_msb_carry
`endif
);
    logic [DIGIT:0] c;
    assign c[0] = i_carry;
    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        assign o_sum[g] = i_x[g] ^ i_y[g] ^ c[g];
        assign c[g+1] = (i_x[g] & i_y[g]) | (c[g] & (i_x[g] ^ i_y[g]));
    end
    assign o_carry = c[DIGIT];
`ifdef SERIAL_ADDER_SUB_EN
    assign o_msb_carry = c[DIGIT-1];
`endif
endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial X+Y+carry with valid/ready handshakes; SERIAL_ADDER_SUB_EN adds subtract and signed overflow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input logic           i_clk,
    input logic           i_rst_n,
    serial_adder_if.slave bus
);
    localparam int N  = steps(WIDTH, DIGIT);
    localparam int CW = N > 1 ? $clog2(N) : 1;

    if (!legal(WIDTH, DIGIT)) begin : g_bad
        $error("serial_adder: DIGIT must lie in 1..WIDTH and divide WIDTH");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] x_q, y_q, sum_q;
    logic             c_q, d_carry;
    logic [DIGIT-1:0] d_sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic             d_msb, ovf_q;
`endif

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .i_x(x_q[DIGIT-1:0]),
        .i_y(y_q[DIGIT-1:0]),
        .i_carry(c_q),
        .o_sum(d_sum),
        .o_carry(d_carry)
`ifdef SERIAL_ADDER_SUB_EN
        ,
        .o_msb_carry(d_msb)
`endif
    );

    // subtract folds into the add path: Y and the carry-in are inverted once at capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            x_q   <= '0;
            y_q   <= '0;
            sum_q <= '0;
            c_q   <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.i_valid) begin
                    state <= BUSY;
                    cnt   <= CW'(N - 1);
                    x_q   <= bus.i_x;
`ifdef SERIAL_ADDER_SUB_EN
                    y_q   <= bus.i_sub ? ~bus.i_y : bus.i_y;
                    c_q   <= bus.i_carry ^ bus.i_sub;
`else
                    y_q   <= bus.i_y;
                    c_q   <= bus.i_carry;
`endif
                end
                BUSY: begin
                    x_q   <= x_q >> DIGIT;
                    y_q   <= y_q >> DIGIT;
                    sum_q <= (sum_q >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));
                    c_q   <= d_carry;
                    if (cnt == '0) begin
                        state <= DONE;
`ifdef SERIAL_ADDER_SUB_EN
                        ovf_q <= d_carry ^ d_msb;
`endif
                    end else
                        cnt <= cnt - 1'b1;
                end
                DONE: if (bus.i_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = state == IDLE;
    assign bus.o_valid = state == DONE;
    assign bus.o_sum   = sum_q;
    assign bus.o_carry = c_q;
`ifdef SERIAL_ADDER_SUB_EN
    assign bus.o_overflow = ovf_q;
`endif
endmodule
